if_fetch_queue: RTL and testbench

- Instruction fetch queue between the PC generator and instruction memory on one side, and the ID stage on the other.
- Pairs each issued fetch address with the instruction returned one cycle later by instruction memory.
- Buffers up to DEPTH {pc, inst} pairs and presents them in order to ID with a valid/ready handshake.
- Drives back-pressure to the PC generator and discards all queued and in-flight fetches on flush.

---
 rtl/if_fetch_queue_pkg.sv | 14 +
 rtl/ifq_ram.sv | 37 +++
 rtl/if_fetch_queue.sv | 127 ++++++++++++
 tb/tb_if_fetch_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path constants for the instruction fetch queue.
// Holds bus widths, reset/enable levels and the all-zero instruction word (a NOP).
package if_fetch_queue_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;

    localparam logic [InstBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/ifq_ram.sv
// Register-array storage for the fetch queue.
// One synchronous write port, one combinational read port, no reset on contents.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational from registered storage)
module ifq_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between PC generator / instruction memory and ID.
// Each accepted fetch address is held for one cycle, paired with the instruction
// memory data returned that cycle, and pushed into a DEPTH-entry in-order queue.
//   clk            clock
//   rst            synchronous active-high reset
//   req_ce_i       fetch request this cycle
//   req_pc_i       fetch address
//   rom_inst_i     instruction memory data (one cycle after its request)
//   flush_i        drop all queued and in-flight fetches
//   fetch_stall_o  back-pressure to the PC generator
//   id_valid_o     head entry valid
//   id_pc_o        head entry address (0 when empty)
//   id_inst_o      head entry instruction (0 when empty)
//   id_ready_i     ID accepts the head entry
//   count_o        occupied entries
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = InstAddrBus,
    parameter int unsigned DW    = InstBus
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_ce_i,
    input  logic [AW-1:0]          req_pc_i,
    input  logic [DW-1:0]          rom_inst_i,
    input  logic                   flush_i,
    output logic                   fetch_stall_o,
    output logic                   id_valid_o,
    output logic [AW-1:0]          id_pc_o,
    output logic [DW-1:0]          id_inst_o,
    input  logic                   id_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned  PW       = $clog2(DEPTH);
    localparam logic [PW+1:0] DepthOcc = (PW+2)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             pend_v_q, pend_v_d;
    logic [AW-1:0]    pend_pc_q, pend_pc_d;

    logic [PW+1:0]    occ;
    logic             stall;
    logic             head_v;
    logic             accept;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] head_entry;

    // Stall counts the in-flight fetch as occupied so a push can never land on a full
    // queue; it ignores a same-cycle pop to stay free of input-to-output paths.
    always_comb begin
        occ    = {1'b0, count_q} + {{(PW+1){1'b0}}, pend_v_q};
        stall  = (occ >= DepthOcc);
        head_v = (count_q != '0);
        accept = (req_ce_i == ChipEnable) & ~stall & ~flush_i;
        push   = pend_v_q & ~flush_i;
        pop    = head_v & id_ready_i & ~flush_i;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pend_v_d  = accept;
        pend_pc_d = accept ? req_pc_i : pend_pc_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    ifq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({pend_pc_q, rom_inst_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    // Storage is unreset, so the empty case must mask whatever it holds.
    always_comb begin
        fetch_stall_o = stall;
        id_valid_o    = head_v;
        id_pc_o       = head_v ? head_entry[AW+DW-1:DW] : '0;
        id_inst_o     = head_v ? head_entry[DW-1:0] : '0;
        count_o       = count_q;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        req_ce_i;
    logic [31:0] req_pc_i;
    logic [31:0] rom_inst_i;
    logic        flush_i;
    logic        fetch_stall_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_queue #(
        .DEPTH (DEPTH),
        .AW    (32),
        .DW    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_ce_i      (req_ce_i),
        .req_pc_i      (req_pc_i),
        .rom_inst_i    (rom_inst_i),
        .flush_i       (flush_i),
        .fetch_stall_o (fetch_stall_o),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_ready_i    (id_ready_i),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: data for an address arrives the cycle after it is presented.
    initial rom_inst_i = '0;
    always @(posedge clk) rom_inst_i <= inst_of(req_pc_i);

    // Push while full must never happen.
    always @(posedge clk) begin
        if (!rst && dut.pend_v_q && !flush_i && dut.count_q == 3'(DEPTH)) begin
            n_checks++;
            $display("FAIL push_when_full at %0t: count=%0d pend=1", $time, dut.count_q);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
    endtask

    task automatic drive(input logic r, input logic ce, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        rst        = r;
        req_ce_i   = ce;
        req_pc_i   = pc;
        id_ready_i = rdy;
        flush_i    = fl;
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [31:0] epc,
                            input logic est, input int ecnt);
        chk({tag, ".valid"}, 32'(id_valid_o), 32'(ev));
        chk({tag, ".pc"},    id_pc_o, ev ? epc : 32'h0);
        chk({tag, ".inst"},  id_inst_o, ev ? inst_of(epc) : 32'h0);
        chk({tag, ".stall"}, 32'(fetch_stall_o), 32'(est));
        chk({tag, ".count"}, 32'(count_o), 32'(ecnt));
    endtask

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic        est;
        int          ecnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ce, input logic [31:0] pc,
                                input logic rdy, input logic fl, input logic ev,
                                input logic [31:0] epc, input logic est, input int ecnt);
        vec_t v;
        v.rst = r; v.ce = ce; v.pc = pc; v.rdy = rdy; v.fl = fl;
        v.ev = ev; v.epc = epc; v.est = est; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t vecs[18];

    logic [31:0] q[$];
    logic        m_pv;
    logic [31:0] m_ppc;
    logic [31:0] next_pc;
    logic        m_stall;
    logic        r_ce, r_rdy, r_fl;
    logic [31:0] r_pc;

    initial begin
        // Expected outputs are those visible before the row's inputs take effect.
        //              rst ce  pc      rdy fl  valid pc     stall cnt
        vecs[0]  = mk(1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 0);
        vecs[1]  = mk(0, 1, 32'h00, 1, 0, 0, 32'h00, 0, 0);
        vecs[2]  = mk(0, 1, 32'h04, 1, 0, 0, 32'h00, 0, 0);
        vecs[3]  = mk(0, 1, 32'h08, 1, 0, 1, 32'h00, 0, 1);
        vecs[4]  = mk(0, 1, 32'h0C, 1, 0, 1, 32'h04, 0, 1);
        vecs[5]  = mk(0, 0, 32'h00, 1, 0, 1, 32'h08, 0, 1);
        vecs[6]  = mk(0, 0, 32'h00, 1, 0, 1, 32'h0C, 0, 1);
        vecs[7]  = mk(0, 1, 32'h00, 0, 0, 0, 32'h00, 0, 0);
        vecs[8]  = mk(0, 1, 32'h04, 0, 0, 0, 32'h00, 0, 0);
        vecs[9]  = mk(0, 1, 32'h08, 0, 0, 1, 32'h00, 0, 1);
        vecs[10] = mk(0, 1, 32'h0C, 0, 0, 1, 32'h00, 0, 2);
        vecs[11] = mk(0, 1, 32'h40, 0, 0, 1, 32'h00, 1, 3);
        vecs[12] = mk(0, 1, 32'h40, 0, 0, 1, 32'h00, 1, 4);
        vecs[13] = mk(0, 0, 32'h00, 1, 0, 1, 32'h00, 1, 4);
        vecs[14] = mk(0, 0, 32'h00, 1, 0, 1, 32'h04, 0, 3);
        vecs[15] = mk(0, 0, 32'h00, 1, 0, 1, 32'h08, 0, 2);
        vecs[16] = mk(0, 0, 32'h00, 1, 0, 1, 32'h0C, 0, 1);
        vecs[17] = mk(0, 0, 32'h00, 1, 0, 0, 32'h00, 0, 0);

        rst = 1'b1; req_ce_i = ChipDisable; req_pc_i = '0; id_ready_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].est, vecs[i].ecnt);
            drive(vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
        end

        // Flush with three queued entries plus one in flight.
        drive(0, 1, 32'h200, 0, 0);
        drive(0, 1, 32'h204, 0, 0);
        drive(0, 1, 32'h208, 0, 0);
        drive(0, 1, 32'h20C, 0, 0);
        chk_outs("pre_flush", 1, 32'h200, 1, 3);
        drive(0, 0, 32'h0, 0, 1);
        chk_outs("post_flush", 0, 32'h0, 0, 0);
        drive(0, 1, 32'h100, 1, 0);
        chk_outs("flush_req1", 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 1, 0);
        chk_outs("flush_req2", 1, 32'h100, 0, 1);
        drive(0, 0, 32'h0, 1, 0);
        chk_outs("flush_drained", 0, 32'h0, 0, 0);

        // Reset mid-stream with two entries queued and a request on the reset cycle.
        drive(0, 1, 32'h300, 0, 0);
        drive(0, 1, 32'h304, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk_outs("pre_rst", 1, 32'h300, 0, 2);
        drive(1, 1, 32'h308, 1, 0);
        chk_outs("post_rst", 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk_outs("post_rst2", 0, 32'h0, 0, 0);

        // Random bubbles and flushes against a queue scoreboard.
        m_pv = 1'b0; m_ppc = '0; next_pc = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            chk("rnd.valid", 32'(id_valid_o), 32'(q.size() != 0));
            chk("rnd.count", 32'(count_o), 32'(q.size()));
            m_stall = (q.size() + int'(m_pv)) >= DEPTH;
            chk("rnd.stall", 32'(fetch_stall_o), 32'(m_stall));
            if (q.size() != 0) begin
                chk("rnd.pc", id_pc_o, q[0]);
                chk("rnd.inst", id_inst_o, inst_of(q[0]));
            end
            r_fl  = ($urandom_range(63) == 0);
            r_rdy = ($urandom_range(3) != 0);
            r_ce  = ($urandom_range(4) != 0);
            r_pc  = m_stall ? (32'hBAD0_0000 + 32'(c) * 4) : next_pc;
            if (r_fl) begin
                q.delete();
                m_pv = 1'b0;
            end else begin
                if (q.size() != 0 && r_rdy) void'(q.pop_front());
                if (m_pv) q.push_back(m_ppc);
                m_pv = r_ce && !m_stall;
                if (m_pv) begin
                    m_ppc   = r_pc;
                    next_pc = next_pc + 4;
                end
            end
            drive(0, r_ce, r_pc, r_rdy, r_fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
